// File: rtl/spi_slave_pkg.sv
// rtl/spi_slave_pkg.sv - State encodings, command codes and counter-width helper for the SPI/RAM slave
package spi_slave_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    CHK_CMD   = 3'b001,
    WRITE     = 3'b010,
    READ_ADD  = 3'b011,
    READ_DATA = 3'b111
  } state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // Bits needed for a counter that must hold 0..max_count inclusive.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/spi_ram_sp.sv
// rtl/spi_ram_sp.sv - Synchronous single-port RAM, 1-cycle read latency, out-of-range accesses ignored
module spi_ram_sp #(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [DATA_SIZE-1:0] wdata,
  output logic [DATA_SIZE-1:0] rdata
);

  localparam int IW = (MEM_DEPTH < 2) ? 1 : $clog2(MEM_DEPTH);
  localparam logic [ADDR_SIZE:0] DEPTH = (ADDR_SIZE + 1)'(MEM_DEPTH);

  logic [DATA_SIZE-1:0] mem [MEM_DEPTH];
  logic                 in_range;
  logic [IW-1:0]        idx;

  assign in_range = {1'b0, addr} < DEPTH;
  assign idx      = addr[IW-1:0];

  always_ff @(posedge clk) begin
    if (we && in_range) mem[idx] <= wdata;
    if (re) rdata <= in_range ? mem[idx] : '0;
  end

endmodule

// File: rtl/spi_ram_slave_p.sv
// rtl/spi_ram_slave_p.sv - Parametrised mode-0 SPI slave with embedded RAM; SPI_BURST_EN enables auto-increment bursts
module spi_ram_slave_p #(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic frame_err
);
  import spi_slave_pkg::*;

  localparam int PW = (ADDR_SIZE > DATA_SIZE) ? ADDR_SIZE : DATA_SIZE;
  localparam int CW = cnt_width(PW);
  localparam logic [CW-1:0] A_LAST = CW'(ADDR_SIZE - 1);
  localparam logic [CW-1:0] W_LAST = CW'(DATA_SIZE - 1);
  localparam logic [CW-1:0] T_LAST = CW'(DATA_SIZE);
  localparam logic [ADDR_SIZE:0] ADDR_TOP = (ADDR_SIZE + 1)'(MEM_DEPTH - 1);
`ifdef SPI_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  state_t               state, state_nxt;
  logic [1:0]           cmd;
  logic [CW-1:0]        cnt;
  logic [PW-2:0]        shreg;
  logic [PW-1:0]        word;
  logic [DATA_SIZE-1:0] tx, tx_src, ram_q;
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr, wr_next, rd_next, ram_addr;
  logic                 done, wr_data_cmd, burst_wr;
  logic                 bit_en, pay_last, tx_last, ram_we, ram_re;

  assign word        = {shreg, MOSI};
  assign wr_data_cmd = (cmd == CMD_WR_DATA);
  assign tx_last     = (cnt == T_LAST);
  assign wr_next     = ({1'b0, wr_addr} >= ADDR_TOP) ? '0 : wr_addr + ADDR_SIZE'(1);
  assign rd_next     = ({1'b0, rd_addr} >= ADDR_TOP) ? '0 : rd_addr + ADDR_SIZE'(1);
  // First bit of every word comes straight from the RAM output; later bits from tx.
  assign tx_src      = (cnt == CW'(1)) ? ram_q : tx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    burst_wr  = BURST && (state == WRITE) && wr_data_cmd;
    bit_en    = 1'b0;
    pay_last  = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = rd_addr;
    if (SS_n) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_nxt = CHK_CMD;
        CHK_CMD: begin
          case ({cmd[1], MOSI})
            CMD_WR_ADDR, CMD_WR_DATA: state_nxt = WRITE;
            CMD_RD_ADDR:              state_nxt = READ_ADD;
            default:                  state_nxt = READ_DATA;
          endcase
        end
        WRITE, READ_ADD: begin
          bit_en   = !done || burst_wr;
          pay_last = bit_en && (cnt == (((state == WRITE) && wr_data_cmd) ? W_LAST : A_LAST));
          ram_addr = wr_addr;
          ram_we   = pay_last && (state == WRITE) && wr_data_cmd;
        end
        READ_DATA: begin
          bit_en = !done || BURST;
          ram_re = (cnt == '0) || (BURST && tx_last);
          if (BURST && tx_last) ram_addr = rd_next;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd       <= '0;
      cnt       <= '0;
      shreg     <= '0;
      tx        <= '0;
      wr_addr   <= '0;
      rd_addr   <= '0;
      done      <= 1'b0;
      MISO      <= 1'b0;
      frame_err <= 1'b0;
    end else if (SS_n) begin
      frame_err <= (state != IDLE) && !done;
      cnt       <= '0;
      shreg     <= '0;
      done      <= 1'b0;
      MISO      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE:    cmd[1] <= MOSI;
        CHK_CMD: cmd[0] <= MOSI;
        WRITE, READ_ADD: begin
          if (bit_en) begin
            shreg <= word[PW-2:0];
            done  <= pay_last;
            cnt   <= pay_last ? '0 : cnt + CW'(1);
            if (pay_last) begin
              if (state == READ_ADD) rd_addr <= word[ADDR_SIZE-1:0];
              else if (!wr_data_cmd) wr_addr <= word[ADDR_SIZE-1:0];
              else if (burst_wr)     wr_addr <= wr_next;
            end
          end
        end
        READ_DATA: begin
          if (cnt == '0) begin
            cnt <= CW'(1);
          end else if (bit_en) begin
            MISO <= tx_src[DATA_SIZE-1];
            tx   <= {tx_src[DATA_SIZE-2:0], 1'b0};
            done <= tx_last;
            if (!tx_last) begin
              cnt <= cnt + CW'(1);
            end else if (BURST) begin
              cnt     <= CW'(1);
              rd_addr <= rd_next;
            end
          end else begin
            MISO <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  spi_ram_sp #(
    .ADDR_SIZE(ADDR_SIZE),
    .DATA_SIZE(DATA_SIZE),
    .MEM_DEPTH(MEM_DEPTH)
  ) RAM_INST (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_addr),
    .wdata(word[DATA_SIZE-1:0]),
    .rdata(ram_q)
  );

endmodule
